// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types and operand-select encodings for the EX hazard/forwarding controller.
package ex_ctrl_pkg;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [3:0] src1;
        logic [3:0] src2;
        logic       use1;
        logic       use2;
        logic [3:0] dest;
        logic       wb_en;
        logic       mem_r_en;
    } stage_info_t;

endpackage

// File: rtl/ex_hazard_ctrl_src_match.sv
// Single producer/consumer register compare: a live writer whose dest equals a used source.
module src_match
    import ex_ctrl_pkg::*;
(
    input  logic       valid_i,
    input  logic       wb_en_i,
    input  logic [3:0] dest_i,
    input  logic       use_i,
    input  logic [3:0] src_i,
    output logic       match_o
);

    assign match_o = valid_i & wb_en_i & use_i & (dest_i == src_i);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard and forwarding controller over a shadow EX/MEM/WB pipeline.
// Build option EX_FORWARDING_EN: forwarding with load-use stall; otherwise stall-only interlock.
module ex_hazard_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             id_src1,
    input  logic [3:0]             id_src2,
    input  logic                   id_two_src,
    input  logic                   id_uses_src1,
    input  logic [3:0]             id_dest,
    input  logic                   id_wb_en,
    input  logic                   id_mem_r_en,
    input  logic                   flush,
    output logic [1:0]             sel_src_1,
    output logic [1:0]             sel_src_2,
    output logic                   hazard_stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    stage_info_t id_info, ex_d, ex_q, mem_q, wb_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic stall_raw;

    always_comb begin
        id_info          = '0;
        id_info.valid    = 1'b1;
        id_info.src1     = id_src1;
        id_info.src2     = id_src2;
        id_info.use1     = id_uses_src1;
        id_info.use2     = id_two_src;
        id_info.dest     = id_dest;
        id_info.wb_en    = id_wb_en;
        id_info.mem_r_en = id_mem_r_en;
    end

    // ID-vs-EX compares are needed in both builds (load-use or plain interlock).
    logic ex_id_1, ex_id_2;
    src_match u_ex_id_1 (.valid_i(ex_q.valid), .wb_en_i(ex_q.wb_en), .dest_i(ex_q.dest),
                         .use_i(id_uses_src1), .src_i(id_src1), .match_o(ex_id_1));
    src_match u_ex_id_2 (.valid_i(ex_q.valid), .wb_en_i(ex_q.wb_en), .dest_i(ex_q.dest),
                         .use_i(id_two_src), .src_i(id_src2), .match_o(ex_id_2));

`ifdef EX_FORWARDING_EN
    logic mem_ex_1, mem_ex_2, wb_ex_1, wb_ex_2;
    src_match u_mem_ex_1 (.valid_i(mem_q.valid), .wb_en_i(mem_q.wb_en), .dest_i(mem_q.dest),
                          .use_i(ex_q.use1), .src_i(ex_q.src1), .match_o(mem_ex_1));
    src_match u_mem_ex_2 (.valid_i(mem_q.valid), .wb_en_i(mem_q.wb_en), .dest_i(mem_q.dest),
                          .use_i(ex_q.use2), .src_i(ex_q.src2), .match_o(mem_ex_2));
    src_match u_wb_ex_1  (.valid_i(wb_q.valid), .wb_en_i(wb_q.wb_en), .dest_i(wb_q.dest),
                          .use_i(ex_q.use1), .src_i(ex_q.src1), .match_o(wb_ex_1));
    src_match u_wb_ex_2  (.valid_i(wb_q.valid), .wb_en_i(wb_q.wb_en), .dest_i(wb_q.dest),
                          .use_i(ex_q.use2), .src_i(ex_q.src2), .match_o(wb_ex_2));

    always_comb begin
        sel_src_1 = SEL_REG;
        sel_src_2 = SEL_REG;
        if (mem_ex_1)     sel_src_1 = SEL_MEM;
        else if (wb_ex_1) sel_src_1 = SEL_WB;
        if (mem_ex_2)     sel_src_2 = SEL_MEM;
        else if (wb_ex_2) sel_src_2 = SEL_WB;
        stall_raw = ex_q.mem_r_en & (ex_id_1 | ex_id_2);
    end

    logic unused_fields;
    assign unused_fields = ^{mem_q.src1, mem_q.src2, mem_q.use1, mem_q.use2, mem_q.mem_r_en,
                             wb_q.src1, wb_q.src2, wb_q.use1, wb_q.use2, wb_q.mem_r_en};
`else
    // Without forwarding the result is only usable once it leaves MEM; WB writes on the falling edge.
    logic mem_id_1, mem_id_2;
    src_match u_mem_id_1 (.valid_i(mem_q.valid), .wb_en_i(mem_q.wb_en), .dest_i(mem_q.dest),
                          .use_i(id_uses_src1), .src_i(id_src1), .match_o(mem_id_1));
    src_match u_mem_id_2 (.valid_i(mem_q.valid), .wb_en_i(mem_q.wb_en), .dest_i(mem_q.dest),
                          .use_i(id_two_src), .src_i(id_src2), .match_o(mem_id_2));

    assign sel_src_1 = SEL_REG;
    assign sel_src_2 = SEL_REG;
    assign stall_raw = ex_id_1 | ex_id_2 | mem_id_1 | mem_id_2;

    logic unused_fields;
    assign unused_fields = ^{ex_q.src1, ex_q.src2, ex_q.use1, ex_q.use2, ex_q.mem_r_en,
                             mem_q.src1, mem_q.src2, mem_q.use1, mem_q.use2, mem_q.mem_r_en,
                             wb_q};
`endif

    assign hazard_stall = stall_raw & ~flush & ~rst;
    assign ex_d         = (hazard_stall | flush) ? '0 : id_info;
    assign stall_cnt_d  = (hazard_stall && (stall_cnt_q != '1)) ? stall_cnt_q + STALL_CNT_W'(1)
                                                                : stall_cnt_q;
    assign stall_cnt    = stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed self-checking bench for ex_hazard_ctrl; expectations follow the EX_FORWARDING_EN build setting.
module tb_ex_hazard_ctrl;

    localparam int CW = 4;

    logic          clk, rst;
    logic [3:0]    id_src1, id_src2, id_dest;
    logic          id_two_src, id_uses_src1, id_wb_en, id_mem_r_en, flush;
    logic [1:0]    sel_src_1, sel_src_2;
    logic          hazard_stall;
    logic [CW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    ex_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_uses_src1(id_uses_src1), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .flush(flush),
        .sel_src_1(sel_src_1), .sel_src_2(sel_src_2),
        .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one ID-stage instruction and let combinational outputs settle.
    task automatic put(input logic [3:0] s1, input logic u1, input logic [3:0] s2, input logic two,
                       input logic [3:0] d, input logic wb, input logic ld, input logic fl);
        id_src1 = s1; id_uses_src1 = u1; id_src2 = s2; id_two_src = two;
        id_dest = d; id_wb_en = wb; id_mem_r_en = ld; flush = fl;
        #1;
    endtask

    task automatic nop();
        put(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        nop();
        #10;
        chk("rst_sel1", sel_src_1, 2'b00);
        chk("rst_sel2", sel_src_2, 2'b00);
        chk("rst_stall", hazard_stall, 1'b0);
        chk("rst_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef EX_FORWARDING_EN
        // ADD R1 -> SUB R1: MEM forward, no stall
        step(); put(4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 0);
        step(); put(4'd1, 1, 4'd4, 1, 4'd5, 1, 0, 0);
        chk("alu_dep_stall", hazard_stall, 1'b0);
        step(); nop();
        chk("fwd_mem_sel1", sel_src_1, 2'b01);
        chk("fwd_mem_sel2", sel_src_2, 2'b00);
        step(); step(); step();

        // writer R2, unrelated, reader Rm=R2: WB forward
        put(4'd7, 1, 4'd8, 1, 4'd2, 1, 0, 0);
        step(); put(4'd9, 1, 4'd10, 1, 4'd11, 1, 0, 0);
        step(); put(4'd0, 0, 4'd2, 1, 4'd12, 1, 0, 0);
        chk("wb_dist_stall", hazard_stall, 1'b0);
        step(); nop();
        chk("fwd_wb_sel2", sel_src_2, 2'b10);
        chk("fwd_wb_sel1", sel_src_1, 2'b00);
        step(); step(); step();

        // LDR R3 ; ADD R4,R3,R5: one stall then WB forward
        put(4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 0);
        step(); put(4'd3, 1, 4'd5, 1, 4'd4, 1, 0, 0);
        chk("ldu_stall", hazard_stall, 1'b1);
        chk("ldu_cnt0", stall_cnt, 0);
        step();
        chk("ldu_release", hazard_stall, 1'b0);
        chk("ldu_cnt1", stall_cnt, 1);
        step(); nop();
        chk("ldu_sel1", sel_src_1, 2'b10);
        chk("ldu_sel2", sel_src_2, 2'b00);
        step(); step(); step();

        // R4 written in both MEM and WB: MEM wins
        put(4'd0, 0, 4'd0, 0, 4'd4, 1, 0, 0);
        step(); put(4'd0, 0, 4'd0, 0, 4'd4, 1, 0, 0);
        step(); put(4'd4, 1, 4'd4, 1, 4'd6, 1, 0, 0);
        step(); nop();
        chk("prio_sel1", sel_src_1, 2'b01);
        chk("prio_sel2", sel_src_2, 2'b01);
        step(); step(); step();

        // LDR R6 with flush on dependent ADD
        put(4'd0, 0, 4'd0, 0, 4'd6, 1, 1, 0);
        step(); put(4'd6, 1, 4'd0, 0, 4'd7, 1, 0, 1);
        chk("flush_stall", hazard_stall, 1'b0);
        step(); nop();
        chk("flush_cnt", stall_cnt, 1);
        chk("flush_bubble_sel1", sel_src_1, 2'b00);
        step(); step(); step();

        // counter saturation: 16 more load-use stalls
        for (int i = 0; i < 16; i++) begin
            put(4'd0, 0, 4'd0, 0, 4'd8, 1, 1, 0);
            step(); put(4'd8, 1, 4'd0, 0, 4'd9, 1, 0, 0);
            step(); nop();
        end
        chk("sat_cnt", stall_cnt, 15);
        step(); step(); step();

        // reset mid-stall
        put(4'd0, 0, 4'd0, 0, 4'd7, 1, 1, 0);
        step(); put(4'd7, 1, 4'd0, 0, 4'd1, 1, 0, 0);
        chk("midrst_pre", hazard_stall, 1'b1);
        rst = 1'b1; #1;
        chk("midrst_stall", hazard_stall, 1'b0);
        chk("midrst_cnt", stall_cnt, 0);
        step(); rst = 1'b0; #1;
        chk("midrst_after", hazard_stall, 1'b0);
`else
        // ADD R1 -> SUB R1: two stall cycles, selects stay 00
        step(); put(4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 0);
        chk("idle_stall", hazard_stall, 1'b0);
        step(); put(4'd1, 1, 4'd4, 1, 4'd5, 1, 0, 0);
        chk("dep_ex_stall", hazard_stall, 1'b1);
        chk("dep_ex_cnt", stall_cnt, 0);
        chk("dep_ex_sel1", sel_src_1, 2'b00);
        step();
        chk("dep_mem_stall", hazard_stall, 1'b1);
        chk("dep_mem_cnt", stall_cnt, 1);
        step();
        chk("dep_wb_stall", hazard_stall, 1'b0);
        chk("dep_wb_cnt", stall_cnt, 2);
        step(); nop();
        chk("dep_sel1", sel_src_1, 2'b00);
        chk("dep_sel2", sel_src_2, 2'b00);
        step(); step(); step();

        // writer R6 in EX; vary use bits and flush on a reader of R6
        put(4'd0, 0, 4'd0, 0, 4'd6, 1, 0, 0);
        step(); put(4'd0, 0, 4'd6, 1, 4'd1, 1, 0, 0);
        chk("src2_used", hazard_stall, 1'b1);
        put(4'd0, 0, 4'd6, 0, 4'd1, 1, 0, 0);
        chk("src2_unused", hazard_stall, 1'b0);
        put(4'd6, 1, 4'd0, 0, 4'd1, 1, 0, 0);
        chk("src1_used", hazard_stall, 1'b1);
        put(4'd6, 0, 4'd0, 0, 4'd1, 1, 0, 0);
        chk("src1_unused", hazard_stall, 1'b0);
        put(4'd6, 1, 4'd6, 1, 4'd1, 1, 0, 1);
        chk("flush_override", hazard_stall, 1'b0);
        step(); put(4'd6, 1, 4'd0, 0, 4'd1, 1, 0, 0);
        chk("writer_in_mem", hazard_stall, 1'b1);
        chk("flush_no_count", stall_cnt, 2);
        step();
        chk("wb_not_checked", hazard_stall, 1'b0);
        chk("cnt_after_mem", stall_cnt, 3);
        nop(); step(); step(); step();

        // writer with wb_en=0 never interlocks
        put(4'd0, 0, 4'd0, 0, 4'd7, 0, 0, 0);
        step(); put(4'd7, 1, 4'd7, 1, 4'd1, 1, 0, 0);
        chk("no_wb_en", hazard_stall, 1'b0);
        nop(); step(); step(); step();

        // counter saturation: 7 dependent pairs, 2 stalls each
        for (int i = 0; i < 7; i++) begin
            put(4'd0, 0, 4'd0, 0, 4'd8, 1, 0, 0);
            step(); put(4'd8, 1, 4'd0, 0, 4'd9, 1, 0, 0);
            step(); step(); step();
        end
        nop();
        chk("sat_cnt", stall_cnt, 15);
        step(); step(); step();

        // reset mid-stall
        put(4'd0, 0, 4'd0, 0, 4'd9, 1, 0, 0);
        step(); put(4'd9, 1, 4'd0, 0, 4'd1, 1, 0, 0);
        chk("midrst_pre", hazard_stall, 1'b1);
        rst = 1'b1; #1;
        chk("midrst_stall", hazard_stall, 1'b0);
        chk("midrst_cnt", stall_cnt, 0);
        step(); rst = 1'b0; #1;
        chk("midrst_after", hazard_stall, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
